// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// Keeps exactly one ALU transaction in flight and routes the response back to its owner.
module alu_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*DATA_WIDTH+2:0] i_req0_cmd,
  input  logic                    i_req0_cmd_valid,
  output logic                    o_req0_cmd_ready,
  output logic [DATA_WIDTH:0]     o_req0_rsp,
  output logic                    o_req0_rsp_valid,
  input  logic                    i_req0_rsp_ready,
  input  logic [2*DATA_WIDTH+2:0] i_req1_cmd,
  input  logic                    i_req1_cmd_valid,
  output logic                    o_req1_cmd_ready,
  output logic [DATA_WIDTH:0]     o_req1_rsp,
  output logic                    o_req1_rsp_valid,
  input  logic                    i_req1_rsp_ready,
  output logic [2*DATA_WIDTH+2:0] o_alu_cmd,
  output logic                    o_alu_cmd_valid,
  input  logic                    i_alu_cmd_ready,
  input  logic [DATA_WIDTH:0]     i_alu_rsp,
  input  logic                    i_alu_rsp_valid,
  output logic                    o_alu_rsp_ready,
  output logic [1:0]              o_grant,
  output logic [1:0]              o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    ptr_q;
  logic [2*DATA_WIDTH+2:0] cmd_q;
  logic [1:0]              grant_q;

  logic is_idle;
  logic pick1;
  logic cmd_hs;
  logic own0;
  logic own1;
  logic rsp_hs;

  // rst_n gates the ready path so no command can be seen as accepted while in reset.
  assign is_idle          = rst_n && (state_q == S_IDLE);
  assign pick1            = i_req1_cmd_valid && (!i_req0_cmd_valid || ptr_q);
  assign o_req1_cmd_ready = is_idle && pick1;
  assign o_req0_cmd_ready = is_idle && i_req0_cmd_valid && !pick1;
  assign cmd_hs           = o_req0_cmd_ready || o_req1_cmd_ready;

  assign own0 = (state_q == S_WAIT) && grant_q[0];
  assign own1 = (state_q == S_WAIT) && grant_q[1];

  assign o_req0_rsp_valid = own0 && i_alu_rsp_valid;
  assign o_req1_rsp_valid = own1 && i_alu_rsp_valid;
  assign o_req0_rsp       = own0 ? i_alu_rsp : '0;
  assign o_req1_rsp       = own1 ? i_alu_rsp : '0;
  assign o_alu_rsp_ready  = (own0 && i_req0_rsp_ready) || (own1 && i_req1_rsp_ready);
  assign rsp_hs           = i_alu_rsp_valid && o_alu_rsp_ready;

  assign o_alu_cmd_valid = (state_q == S_ISSUE);
  assign o_alu_cmd       = cmd_q;
  assign o_grant         = grant_q;
  assign o_dbg_state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      cmd_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_hs) begin
            state_q <= S_ISSUE;
            cmd_q   <= pick1 ? i_req1_cmd : i_req0_cmd;
            grant_q <= pick1 ? 2'b10 : 2'b01;
            ptr_q   <= !pick1;
          end
        end
        S_ISSUE: begin
          if (i_alu_cmd_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (rsp_hs) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the operand and result width in bits.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_req0_cmd  input  2*DATA_WIDTH+3  requester 0 (calculator core) command, packed as {signed, op[1:0], b, a} with a in the LSBs.
REQ-005 i_req0_cmd_valid  input  1  requester 0 command valid.
REQ-006 o_req0_cmd_ready  output  1  requester 0 command accepted this cycle.
REQ-007 o_req0_rsp  output  DATA_WIDTH+1  requester 0 response, packed as {error, result}.
REQ-008 o_req0_rsp_valid  output  1  requester 0 response valid.
REQ-009 i_req0_rsp_ready  input  1  requester 0 can take the response.
REQ-010 i_req1_cmd, i_req1_cmd_valid, o_req1_cmd_ready, o_req1_rsp, o_req1_rsp_valid, i_req1_rsp_ready SHALL mirror REQ-004..009 in direction, width and meaning for requester 1 (the output driver's binary-to-BCD divide path).
REQ-011 o_alu_cmd  output  2*DATA_WIDTH+3  command to the ALU, same packing as REQ-004.
REQ-012 o_alu_cmd_valid  output  1  ALU command valid.
REQ-013 i_alu_cmd_ready  input  1  ALU accepts the command.
REQ-014 i_alu_rsp  input  DATA_WIDTH+1  ALU response, packed as {error, result}.
REQ-015 i_alu_rsp_valid  input  1  ALU response valid.
REQ-016 o_alu_rsp_ready  output  1  arbiter can take the ALU response.
REQ-017 o_grant  output  2  one-hot owner of the ALU: bit0 = requester 0, bit1 = requester 1; 00 when IDLE.

Function
REQ-018 SHALL implement an FSM with three states, and only these transitions:
- IDLE: goes to ISSUE on a command handshake.
- ISSUE: goes to WAIT when o_alu_cmd_valid and i_alu_cmd_ready are both high.
- WAIT: goes to IDLE on a response handshake with the owner.
REQ-019 SHALL keep exactly one ALU transaction outstanding; no command is accepted outside IDLE.
REQ-020 Arbitration in IDLE:
- a valid requester alone wins;
- if both are valid in the same cycle, the requester named by the 1-bit priority pointer wins.
REQ-021 In IDLE, the winner's cmd_ready SHALL be asserted combinationally in the same cycle as its cmd_valid; the loser's cmd_ready SHALL be 0.
REQ-022 On a command handshake:
- the winner's command is registered;
- o_grant is set to the winner;
- the priority pointer is set to the other requester (round-robin).
REQ-023 o_alu_cmd_valid SHALL be high exactly in ISSUE, driven from the registered command; the command SHALL be held stable until i_alu_cmd_ready.
REQ-024 Latency: a command accepted in cycle T SHALL appear on o_alu_cmd_valid in cycle T+1.
REQ-025 In WAIT, routing to the owner:
- the owner's rsp_valid SHALL equal i_alu_rsp_valid;
- the owner's rsp SHALL equal i_alu_rsp;
- o_alu_rsp_ready SHALL equal the owner's rsp_ready.
All routing is combinational, with zero added latency.
REQ-026 Outside WAIT, and always for the non-owner: rsp_valid SHALL be 0 and rsp SHALL be 0.
REQ-027 In IDLE and ISSUE, o_alu_rsp_ready SHALL be 0.
REQ-028 Fields of the command and response (a, b, op, signed, result, error) SHALL pass unmodified; the arbiter performs no arithmetic.
REQ-029 In the cycle the response handshake completes, o_grant SHALL still show the owner; it reads 00 from the next cycle.
REQ-030 A requester that drops cmd_valid before being granted SHALL cause no state change.

Reset
REQ-031 While rst_n is low, asynchronously:
- the FSM is in IDLE and the priority pointer is 0;
- the command register and o_grant are 0;
- o_alu_cmd_valid and o_alu_rsp_ready are 0;
- both cmd_ready outputs are 0 and both rsp_valid outputs are 0.
REQ-032 A reset in ISSUE or WAIT SHALL abandon the transaction; no response is delivered after reset. The ALU shares rst_n.
REQ-033 In the first cycle after reset release, arbitration SHALL follow REQ-020 with pointer 0.

Verification
REQ-034 Reset mid-WAIT (owner requester 1) -> o_grant = 00, o_alu_rsp_ready = 0 and both rsp_valid = 0 immediately (asynchronously); next contention is won by requester 0.
REQ-035 Requester 0 only, a=0x0007, b=0x0003, op=00, signed=0:
- o_req0_cmd_ready is 1 the same cycle;
- next cycle o_alu_cmd = {0, 00, 0x0003, 0x0007} with valid = 1;
- ALU returns {0, 0x000A} -> o_req0_rsp = 0x000A and o_req0_rsp_valid = 1, while o_req1_rsp_valid = 0.
REQ-036 Both requesters hold valid continuously for 4 transactions after reset -> grants are req0, req1, req0, req1.
REQ-037 i_alu_cmd_ready held low 5 cycles in ISSUE -> o_alu_cmd_valid stays 1 and o_alu_cmd is unchanged for all 5 cycles; no new command is accepted.
REQ-038 Requester 1 divide with b=0 -> ALU returns {1, 0x0000}; with i_req1_rsp_ready held low 3 cycles, o_alu_rsp_ready stays 0 and o_req1_rsp = 0x10000 is held; on the handshake, o_grant = 00 the next cycle.
